// File: rtl/regbank_scan_if.sv
// regbank_scan bus: write port, preset, read request/response and scan stream.
// Optional REGBANK_SCAN_PARITY_EN adds rd_parity/scan_parity.
interface regbank_scan_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             preset;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req;
    logic [AW-1:0]    rd_addr;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             scan_start;
    logic             scan_busy;
    logic             scan_valid;
    logic [AW-1:0]    scan_addr;
    logic [WIDTH-1:0] scan_data;
    logic             scan_done;
`ifdef REGBANK_SCAN_PARITY_EN
    logic             rd_parity;
    logic             scan_parity;
`endif

    modport master (
        output preset, wr_en, wr_addr, wr_data,
        output rd_req, rd_addr, scan_start,
        input  rd_valid, rd_data,
        input  scan_busy, scan_valid, scan_addr, scan_data, scan_done
`ifdef REGBANK_SCAN_PARITY_EN
        , input rd_parity, scan_parity
`endif
    );

    modport slave (
        input  preset, wr_en, wr_addr, wr_data,
        input  rd_req, rd_addr, scan_start,
        output rd_valid, rd_data,
        output scan_busy, scan_valid, scan_addr, scan_data, scan_done
`ifdef REGBANK_SCAN_PARITY_EN
        , output rd_parity, scan_parity
`endif
    );
endinterface

// File: rtl/regbank_scan.sv
// DEPTH x WIDTH register bank with registered readout and a full-array scan walker.
// Define REGBANK_SCAN_PARITY_EN to store an even-parity bit per entry.
module regbank_scan #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input logic           clock,
    input logic           clear,
    regbank_scan_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LIM  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic ONES_PAR = 1'(WIDTH % 2);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] scan_data_q;
    logic             wr_ok, rd_ok;

    assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < LIM);
    assign rd_ok = {1'b0, bus.rd_addr} < LIM;

`ifdef REGBANK_SCAN_PARITY_EN
    logic par [DEPTH];
    logic scan_par_q;

    // parity storage tracks every array update
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
        end else if (bus.preset) begin
            for (int i = 0; i < DEPTH; i++) par[i] <= ONES_PAR;
        end else if (wr_ok) begin
            par[bus.wr_addr] <= ^bus.wr_data;
        end
    end

    // registered read parity; out-of-range reads return 0
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            bus.rd_parity <= 1'b0;
        else if (bus.rd_req)
            bus.rd_parity <= rd_ok ? par[bus.rd_addr] : 1'b0;
    end

    // scan parity follows scan data
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            scan_par_q <= 1'b0;
        else
            scan_par_q <= (state_d == SCAN) ? par[idx_d] : 1'b0;
    end

    assign bus.scan_parity = scan_par_q;
`endif

    // storage: preset beats write, out-of-range writes dropped
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.preset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // read path: one-cycle latency, data holds when idle
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_req;
            if (bus.rd_req)
                bus.rd_data <= rd_ok ? mem[bus.rd_addr] : '0;
        end
    end

    // scan state, index and captured entry
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            scan_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scan_data_q <= (state_d == SCAN) ? mem[idx_d] : '0;
        end
    end

    // scan next state; start only honoured in IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.scan_start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // scan outputs decoded from registered state
    always_comb begin
        bus.scan_busy  = (state_q != IDLE);
        bus.scan_valid = (state_q == SCAN);
        bus.scan_done  = (state_q == DONE);
        bus.scan_addr  = idx_q;
        bus.scan_data  = scan_data_q;
    end
endmodule

// File: tb/tb_regbank_scan.sv
// Directed bench for regbank_scan: a DEPTH=4 and a DEPTH=5 instance.
module tb_regbank_scan;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regbank_scan_if #(.WIDTH(4), .DEPTH(4)) b ();
    regbank_scan_if #(.WIDTH(4), .DEPTH(5)) c ();

    regbank_scan #(.WIDTH(4), .DEPTH(4)) dut4 (
        .clock(clock), .clear(clear), .bus(b)
    );
    regbank_scan #(.WIDTH(4), .DEPTH(5)) dut5 (
        .clock(clock), .clear(clear), .bus(c)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : main
        logic [3:0] exp4 [4];
        exp4[0] = 4'hA; exp4[1] = 4'h5; exp4[2] = 4'h3; exp4[3] = 4'hC;

        b.preset = 0; b.wr_en = 0; b.wr_addr = 0; b.wr_data = 0;
        b.rd_req = 0; b.rd_addr = 0; b.scan_start = 0;
        c.preset = 0; c.wr_en = 0; c.wr_addr = 0; c.wr_data = 0;
        c.rd_req = 0; c.rd_addr = 0; c.scan_start = 0;
        step();
        step();
        clear = 1'b0;

        chk("reset_rd_valid", 32'(b.rd_valid), 0);
        chk("reset_rd_data", 32'(b.rd_data), 0);
        chk("reset_busy", 32'(b.scan_busy), 0);
        chk("reset_scan_valid", 32'(b.scan_valid), 0);
        chk("reset_scan_done", 32'(b.scan_done), 0);

        for (int i = 0; i < 4; i++) begin
            b.rd_req = 1; b.rd_addr = 2'(i);
            step();
            chk("rst_read_valid", 32'(b.rd_valid), 1);
            chk("rst_read_data", 32'(b.rd_data), 0);
        end
        b.rd_req = 0;
        step();
        chk("rd_idle_valid", 32'(b.rd_valid), 0);

        for (int i = 0; i < 4; i++) begin
            b.wr_en = 1; b.wr_addr = 2'(i); b.wr_data = exp4[i];
            step();
        end
        b.wr_en = 0;
        b.scan_start = 1;
        step();
        b.scan_start = 0;
        for (int i = 0; i < 4; i++) begin
            chk("scan1_valid", 32'(b.scan_valid), 1);
            chk("scan1_busy", 32'(b.scan_busy), 1);
            chk("scan1_addr", 32'(b.scan_addr), 32'(i));
            chk("scan1_data", 32'(b.scan_data), 32'(exp4[i]));
            step();
        end
        chk("scan1_done", 32'(b.scan_done), 1);
        chk("scan1_done_valid", 32'(b.scan_valid), 0);
        chk("scan1_done_busy", 32'(b.scan_busy), 1);
        step();
        chk("scan1_idle_busy", 32'(b.scan_busy), 0);
        chk("scan1_idle_done", 32'(b.scan_done), 0);

        b.preset = 1; b.wr_en = 1; b.wr_addr = 2; b.wr_data = 4'h0;
        step();
        b.preset = 0; b.wr_en = 1; b.wr_addr = 1; b.wr_data = 4'h9;
        b.rd_req = 1; b.rd_addr = 1;
        step();
        chk("rbw_data", 32'(b.rd_data), 'hF);
        b.wr_en = 0; b.rd_addr = 2;
        step();
        chk("preset_wins", 32'(b.rd_data), 'hF);
        b.rd_addr = 1;
        step();
        chk("write_after", 32'(b.rd_data), 'h9);
        b.rd_req = 0;
        step();
        chk("rd_hold_valid", 32'(b.rd_valid), 0);
        chk("rd_hold_data", 32'(b.rd_data), 'h9);

        b.scan_start = 1;
        step();
        chk("scan2_a0", 32'(b.scan_data), 'hF);
        step();
        chk("scan2_a1_addr", 32'(b.scan_addr), 1);
        chk("scan2_a1", 32'(b.scan_data), 'h9);
        b.wr_en = 1; b.wr_addr = 3; b.wr_data = 4'h7;
        step();
        b.wr_en = 0;
        chk("scan2_a2_addr", 32'(b.scan_addr), 2);
        chk("scan2_a2", 32'(b.scan_data), 'hF);
        step();
        chk("scan2_a3_addr", 32'(b.scan_addr), 3);
        chk("scan2_a3", 32'(b.scan_data), 'h7);
        step();
        chk("scan2_done", 32'(b.scan_done), 1);
        step();
        chk("scan2_no_restart", 32'(b.scan_busy), 0);
        chk("scan2_single_done", 32'(b.scan_done), 0);
        b.scan_start = 0;

        b.rd_req = 1; b.rd_addr = 3;
        step();
        b.rd_req = 0;
        chk("rd_entry7", 32'(b.rd_data), 'h7);
`ifdef REGBANK_SCAN_PARITY_EN
        chk("rd_parity7", 32'(b.rd_parity), 1);
`endif

        c.wr_en = 1; c.wr_addr = 3'd4; c.wr_data = 4'h6;
        step();
        c.wr_addr = 3'd6; c.wr_data = 4'hB;
        step();
        c.wr_en = 0; c.scan_start = 1;
        step();
        c.scan_start = 0;
        for (int i = 0; i < 5; i++) begin
            chk("d5_scan_addr", 32'(c.scan_addr), 32'(i));
            chk("d5_scan_data", 32'(c.scan_data), (i == 4) ? 'h6 : 'h0);
            step();
        end
        chk("d5_done", 32'(c.scan_done), 1);
        c.rd_req = 1; c.rd_addr = 3'd6;
        step();
        c.rd_req = 0;
        chk("d5_oor_valid", 32'(c.rd_valid), 1);
        chk("d5_oor_data", 32'(c.rd_data), 0);

        b.scan_start = 1;
        step();
        b.scan_start = 0;
        step();
        step();
        chk("abort_at_addr2", 32'(b.scan_addr), 2);
        #2;
        clear = 1'b1;
        #1;
        chk("abort_valid", 32'(b.scan_valid), 0);
        chk("abort_busy", 32'(b.scan_busy), 0);
        chk("abort_addr", 32'(b.scan_addr), 0);
        chk("abort_data", 32'(b.scan_data), 0);
        chk("abort_rd_data", 32'(b.rd_data), 0);
        step();
        clear = 1'b0;
        step();
        chk("abort_no_done", 32'(b.scan_done), 0);
        step();
        chk("abort_no_done2", 32'(b.scan_done), 0);
        b.rd_req = 1; b.rd_addr = 3;
        step();
        b.rd_req = 0;
        chk("cleared_entry", 32'(b.rd_data), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regbank_scan.md
Name: regbank_scan

Overview:
- Parametrised successor to the single-bit dff / 2:1 multiplexer test targets.
- DEPTH channels of WIDTH-bit registers, each with synchronous preset and global asynchronous clear.
- Read path: registered N:1 mux readout with request/valid handshake.
- Scan engine walks every entry, one per cycle, so VPI/PLI tests can dump and compare array contents against the hierarchy.

Parameters:
- WIDTH, 4, bits per entry (>=1)
- DEPTH, 4, number of entries (>=2, need not be a power of two)
- AW, $clog2(DEPTH), address width (derived localparam, not overridable)

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  asynchronous active-high reset
- preset  input  1  synchronous; loads all entries with all-ones
- wr_en  input  1  write strobe
- wr_addr  input  AW  write index
- wr_data  input  WIDTH  write data
- rd_req  input  1  read request
- rd_addr  input  AW  read index
- rd_valid  output  1  read data valid
- rd_data  output  WIDTH  read data
- scan_start  input  1  start a full-array walk
- scan_busy  output  1  scan in progress
- scan_valid  output  1  scan_addr/scan_data valid this cycle
- scan_addr  output  AW  index being emitted
- scan_data  output  WIDTH  entry contents
- scan_done  output  1  one-cycle pulse after the last entry

Behaviour:
- Clock and reset: one clock (clock); reset clear is asynchronous and active-high.
- Reset: on clear, all entries are 0; rd_valid, rd_data, scan_busy, scan_valid, scan_addr, scan_data and scan_done are 0; FSM goes to IDLE.
- Storage update priority, at each edge: preset > wr_en.
  - preset with wr_en in the same cycle: the array ends all-ones and the write is dropped.
- Write: entry wr_addr takes wr_data at the edge.
  - wr_addr >= DEPTH: write ignored, no entry changes.
- Read: rd_req sampled at edge N drives rd_valid=1 and rd_data for the cycle after that edge (1-cycle latency).
  - Read-before-write: a same-cycle write or preset to that index is not visible.
  - rd_req=0 gives rd_valid=0 next cycle; rd_data holds its last value.
  - rd_addr >= DEPTH gives rd_valid=1, rd_data=0.
  - Back-to-back rd_req is sustained at one result per cycle; no backpressure.
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE: scan_start=1 -> SCAN with index 0; otherwise stay in IDLE.
  - SCAN: each cycle registers scan_valid=1, scan_addr=index, scan_data=entry[index] (pre-edge value); index increments.
  - SCAN, after index DEPTH-1 is emitted -> DONE.
  - DONE: scan_done=1 and scan_valid=0 for exactly one cycle -> IDLE.
  - scan_busy=1 throughout SCAN and DONE.
  - Total: DEPTH valid cycles plus 1 done cycle. First scan_valid appears the cycle after the start edge.
- scan_start while busy is ignored, including in the DONE cycle. A restart is accepted in IDLE only.
- Writes and preset during a scan are allowed.
  - Already-emitted entries are not re-emitted.
  - Later entries show the updated value.
  - Same-cycle write to the entry being emitted shows the old value.
- clear mid-scan aborts the scan: no scan_done, all scan outputs 0, state IDLE.
- Read path and scan run concurrently and independently.

Optional Feature:
- Macro: REGBANK_SCAN_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed at write/preset/clear.
  - Outputs rd_parity and scan_parity (1 bit each) are registered alongside rd_data/scan_data.
  - Out-of-range read gives rd_parity=0.
- Undefined: no parity storage, and these ports do not exist.

Test Plan:
- Reset, then rd_req with rd_addr=0..3 on consecutive cycles -> rd_valid=1 from the next cycle, rd_data=0 each cycle.
- WIDTH=4, DEPTH=4: write 4'hA@0, 4'h5@1, 4'h3@2, 4'hC@3, then scan_start.
  - scan_valid for 4 cycles: addr 0..3, data A,5,3,C.
  - scan_done 1 cycle later; scan_busy=0 the cycle after that.
- Same cycle: preset=1, wr_en=1, wr_addr=2, wr_data=4'h0; next read of addr 2 -> 4'hF.
- During scan, write 4'h7@3 in the cycle addr 1 is emitted -> scan shows addr 3 = 7; a second scan_start during the busy cycles is ignored (exactly one scan_done).
- DEPTH=5 (AW=3): write to address 6 leaves the array unchanged; read of address 6 -> rd_valid=1, rd_data=0.
- Assert clear asynchronously mid-scan at addr 2 -> all outputs 0 immediately, no scan_done; with REGBANK_SCAN_PARITY_EN, a read of entry 4'h7 gives rd_parity=1.
